// File: rtl/data_cache_ctrl_pkg.sv
// data_cache_ctrl_pkg: shared defaults and FSM state encoding for the data cache
package data_cache_ctrl_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LINES = 64;
  localparam int DEF_WORDS = 4;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;
endpackage

// File: rtl/data_cache_ctrl_array.sv
// data_cache_ctrl_array: valid/tag/data storage with combinational read and one word-write port
module data_cache_ctrl_array
  import data_cache_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(LINES),
  parameter int OFF_W = $clog2(WORDS)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_W-1:0] data [LINES][WORDS];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = data[rd_idx][rd_word];
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (fill) valid[fill_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (fill) tags[fill_idx] <= fill_tag;
    if (we) data[wr_idx][wr_word] <= wr_data;
  end
endmodule

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache with line refill
module data_cache_ctrl
  import data_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_READY
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = IDX_W + OFF_W + 2;
  localparam int TAG_W = ADDR_W - TAG_LO;
  state_t state, state_n;
  logic [OFF_W-1:0] cnt, cnt_n, word;
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag, rd_tag;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic rd_n, wr_n, rd_valid, hit, refill_beat, last_beat, we, unused_ok;
  assign unused_ok = &{1'b0, Addr[1:0]};
  assign word = Addr[IDX_LO-1:2];
  assign idx = Addr[TAG_LO-1:IDX_LO];
  assign tag = Addr[ADDR_W-1:TAG_LO];
  // The line being refilled is named by the held request address, not by Addr
  assign fill_idx = MEM_ADDR[TAG_LO-1:IDX_LO];
  assign fill_tag = MEM_ADDR[ADDR_W-1:TAG_LO];
  assign hit = rd_valid && rd_tag == tag;
  assign refill_beat = state == REFILL && MEM_READY;
  assign last_beat = refill_beat && &cnt;
  assign we = refill_beat || (state == IDLE && MemWrite && hit);
  data_cache_ctrl_array #(
    .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W)
  ) u_array (
    .clk(CLK),
    .rst(RST),
    .rd_idx(idx),
    .rd_word(word),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(ReadData),
    .we(we),
    .wr_idx(state == REFILL ? fill_idx : idx),
    .wr_word(state == REFILL ? cnt : word),
    .wr_data(state == REFILL ? MEM_RDATA : WriteData),
    .fill(last_beat),
    .fill_idx(fill_idx),
    .fill_tag(fill_tag)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      MEM_RD <= 1'b0;
      MEM_WR <= 1'b0;
      MEM_ADDR <= '0;
      MEM_WDATA <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      MEM_RD <= rd_n;
      MEM_WR <= wr_n;
      MEM_ADDR <= addr_n;
      MEM_WDATA <= wdata_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rd_n = MEM_RD;
    wr_n = MEM_WR;
    addr_n = MEM_ADDR;
    wdata_n = MEM_WDATA;
    Stall = 1'b0;
    case (state)
      IDLE: begin
        if (MemWrite) begin
          state_n = WRITE;
          wr_n = 1'b1;
          addr_n = {Addr[ADDR_W-1:2], 2'b00};
          wdata_n = WriteData;
          Stall = 1'b1;
        end else if (MemRead && !hit) begin
          state_n = REFILL;
          cnt_n = '0;
          rd_n = 1'b1;
          addr_n = {tag, idx, {OFF_W{1'b0}}, 2'b00};
          Stall = 1'b1;
        end
      end
      REFILL: begin
        Stall = 1'b1;
        if (MEM_READY) begin
          cnt_n = cnt + 1'b1;
          addr_n = {fill_tag, fill_idx, cnt_n, 2'b00};
          rd_n = !last_beat;
          state_n = last_beat ? IDLE : REFILL;
        end
      end
      WRITE: begin
        Stall = 1'b1;
        wr_n = !MEM_READY;
        state_n = MEM_READY ? WDONE : WRITE;
      end
      WDONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assert property (@(posedge CLK) disable iff (RST) !(MemRead && MemWrite))
    else $error("MemRead and MemWrite asserted together");
  assert property (@(posedge CLK) disable iff (RST) !(MEM_RD && MEM_WR))
    else $error("MEM_RD and MEM_WR asserted together");
endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl: randomized self-checking bench against a line-presence cache model
module tb_data_cache_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic MemRead = 1'b0;
  logic MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData, MEM_ADDR, MEM_WDATA;
  logic [31:0] MEM_RDATA = '0;
  logic Stall, MEM_RD, MEM_WR;
  logic MEM_READY = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  data_cache_ctrl dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY)
  );
  logic [31:0] mem [int unsigned];
  logic [31:0] exp_mem [int unsigned];
  bit m_valid [64];
  logic [27:0] m_line [64];
  int ready_delay = 0;
  int wait_cnt = 0;
  logic [31:0] rd_beats [$];
  int wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_1E0F;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction
  // Direct-mapped with 16-byte lines and 64 lines: index is a[9:4], line address a[31:4]
  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && m_line[a[9:4]] == a[31:4];
  endfunction
  function automatic void m_fill(input logic [31:0] a);
    m_valid[a[9:4]] = 1'b1;
    m_line[a[9:4]] = a[31:4];
  endfunction
  always @(negedge CLK) begin
    MEM_RDATA = mem_rd(MEM_ADDR);
    if (MEM_RD || MEM_WR) begin
      if (wait_cnt >= ready_delay) begin
        MEM_READY = 1'b1;
        wait_cnt = 0;
        if (MEM_RD) rd_beats.push_back(MEM_ADDR);
        if (MEM_WR) begin
          mem[MEM_ADDR] = MEM_WDATA;
          wr_count++;
          last_wr_addr = MEM_ADDR;
          last_wr_data = MEM_WDATA;
        end
      end else begin
        MEM_READY = 1'b0;
        wait_cnt++;
      end
    end else begin
      MEM_READY = ready_delay == 0;
      wait_cnt = 0;
    end
  end
  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int stalls);
    @(negedge CLK);
    MemRead = 1'b1;
    Addr = a;
    stalls = 0;
    #1;
    while (Stall && stalls < 200) begin
      @(negedge CLK);
      #1;
      stalls++;
    end
    d = ReadData;
    @(posedge CLK);
    #1;
    MemRead = 1'b0;
  endtask
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    @(negedge CLK);
    MemWrite = 1'b1;
    Addr = a;
    WriteData = d;
    stalls = 0;
    #1;
    while (Stall && stalls < 200) begin
      @(negedge CLK);
      #1;
      stalls++;
    end
    @(posedge CLK);
    #1;
    MemWrite = 1'b0;
  endtask
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({Stall, MEM_RD, MEM_WR} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000", {Stall, MEM_RD, MEM_WR});
    end
    checks++;
    if (MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got addr=%h wdata=%h exp=0/0", MEM_ADDR, MEM_WDATA);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask
  task automatic test_cold_load();
    logic [31:0] d;
    int st;
    ready_delay = 0;
    rd_beats.delete();
    do_load(32'h100, d, st);
    checks++;
    if (st !== 5) begin
      failures++;
      $display("FAIL cold_stall got=%0d exp=5", st);
    end
    checks++;
    if (d !== exp_rd(32'h100)) begin
      failures++;
      $display("FAIL cold_data got=%h exp=%h", d, exp_rd(32'h100));
    end
    checks++;
    if (rd_beats.size() !== 4) begin
      failures++;
      $display("FAIL cold_beat_count got=%0d exp=4", rd_beats.size());
    end
    for (int i = 0; i < 4 && i < rd_beats.size(); i++) begin
      checks++;
      if (rd_beats[i] !== 32'h100 + 32'(4 * i)) begin
        failures++;
        $display("FAIL cold_beat%0d got=%h exp=%h", i, rd_beats[i], 32'h100 + 32'(4 * i));
      end
    end
    m_fill(32'h100);
  endtask
  task automatic test_hit();
    logic [31:0] d;
    int st;
    rd_beats.delete();
    do_load(32'h108, d, st);
    checks++;
    if (st !== 0) begin
      failures++;
      $display("FAIL hit_stall got=%0d exp=0", st);
    end
    checks++;
    if (d !== exp_rd(32'h108)) begin
      failures++;
      $display("FAIL hit_data got=%h exp=%h", d, exp_rd(32'h108));
    end
    checks++;
    if (rd_beats.size() !== 0) begin
      failures++;
      $display("FAIL hit_mem_rd got=%0d beats exp=0", rd_beats.size());
    end
  endtask
  task automatic test_store_hit();
    logic [31:0] d;
    int st, wc;
    wc = wr_count;
    do_store(32'h104, 32'hDEAD_BEEF, st);
    exp_mem[32'h104] = 32'hDEAD_BEEF;
    checks++;
    if (st !== 2) begin
      failures++;
      $display("FAIL store_hit_stall got=%0d exp=2", st);
    end
    checks++;
    if (wr_count !== wc + 1 || last_wr_addr !== 32'h104 || last_wr_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_hit_mem got n=%0d a=%h d=%h exp n=%0d a=104 d=deadbeef",
               wr_count - wc, last_wr_addr, last_wr_data, 1);
    end
    do_load(32'h104, d, st);
    checks++;
    if (st !== 0 || d !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_hit_reload got stall=%0d d=%h exp stall=0 d=deadbeef", st, d);
    end
  endtask
  task automatic test_store_miss();
    logic [31:0] d, v;
    int st, wc;
    v = $urandom;
    wc = wr_count;
    do_store(32'h2000, v, st);
    exp_mem[32'h2000] = v;
    checks++;
    if (wr_count !== wc + 1 || last_wr_addr !== 32'h2000 || last_wr_data !== v) begin
      failures++;
      $display("FAIL store_miss_mem got a=%h d=%h exp a=2000 d=%h", last_wr_addr, last_wr_data, v);
    end
    rd_beats.delete();
    do_load(32'h2000, d, st);
    m_fill(32'h2000);
    checks++;
    if (st !== 5 || d !== v || rd_beats.size() !== 4) begin
      failures++;
      $display("FAIL store_miss_reload got stall=%0d d=%h beats=%0d exp 5/%h/4", st, d, rd_beats.size(), v);
    end
  endtask
  task automatic test_conflict();
    logic [31:0] d;
    int st;
    do_load(32'h500, d, st);
    m_fill(32'h500);
    checks++;
    if (st !== 5 || d !== exp_rd(32'h500)) begin
      failures++;
      $display("FAIL conflict_load got stall=%0d d=%h exp 5/%h", st, d, exp_rd(32'h500));
    end
    do_load(32'h100, d, st);
    m_fill(32'h100);
    checks++;
    if (st !== 5 || d !== exp_rd(32'h100)) begin
      failures++;
      $display("FAIL conflict_evict got stall=%0d d=%h exp 5/%h", st, d, exp_rd(32'h100));
    end
  endtask
  task automatic test_reset_mid_refill();
    logic [31:0] d;
    int n, st;
    ready_delay = 3;
    rd_beats.delete();
    @(negedge CLK);
    MemRead = 1'b1;
    Addr = 32'h300;
    n = 0;
    while (rd_beats.size() < 1 && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (rd_beats.size() < 1) begin
      failures++;
      $display("FAIL rst_refill_first_beat got=0 beats exp=1 within 100 cycles");
    end
    @(negedge CLK);
    RST = 1'b1;
    MemRead = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if ({Stall, MEM_RD, MEM_WR} !== 3'b000 || MEM_ADDR !== 32'h0) begin
      failures++;
      $display("FAIL rst_refill_state got stall/rd/wr=%b addr=%h exp 000/0", {Stall, MEM_RD, MEM_WR}, MEM_ADDR);
    end
    @(negedge CLK);
    RST = 1'b0;
    ready_delay = 0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    rd_beats.delete();
    do_load(32'h100, d, st);
    m_fill(32'h100);
    checks++;
    if (st !== 5 || d !== exp_rd(32'h100) || rd_beats.size() !== 4) begin
      failures++;
      $display("FAIL rst_refill_reload got stall=%0d d=%h beats=%0d exp 5/%h/4", st, d, rd_beats.size(), exp_rd(32'h100));
    end
  endtask
  task automatic test_random();
    logic [31:0] a, d, v;
    int st, wc, exp_st;
    bit h;
    for (int i = 0; i < 80; i++) begin
      a = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      ready_delay = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) begin
        v = $urandom;
        wc = wr_count;
        do_store(a, v, st);
        exp_mem[a] = v;
        checks++;
        if (st !== ready_delay + 2 || wr_count !== wc + 1 || last_wr_addr !== a || last_wr_data !== v) begin
          failures++;
          $display("FAIL rand_store%0d got stall=%0d n=%0d a=%h d=%h exp %0d/1/%h/%h",
                   i, st, wr_count - wc, last_wr_addr, last_wr_data, ready_delay + 2, a, v);
        end
      end else begin
        h = m_hit(a);
        exp_st = h ? 0 : 4 * (ready_delay + 1) + 1;
        rd_beats.delete();
        do_load(a, d, st);
        if (!h) m_fill(a);
        checks++;
        if (st !== exp_st || d !== exp_rd(a) || rd_beats.size() !== (h ? 0 : 4)) begin
          failures++;
          $display("FAIL rand_load%0d a=%h got stall=%0d d=%h beats=%0d exp %0d/%h/%0d",
                   i, a, st, d, rd_beats.size(), exp_st, exp_rd(a), h ? 0 : 4);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_cold_load();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
